// File: rtl/uart_cfg_cmd_ctrl.sv
// UART command controller: splits RX bytes into payload and register commands, owns the UART
// config registers and schedules read responses on the shared TX. Optional macro CMD_ECHO_EN.
module uart_cfg_cmd_ctrl #(
  parameter logic [3:0] PARITY_RST = 4'h1,
  parameter logic [3:0] FLEN_RST   = 4'h8,
  parameter logic [3:0] BAUD_RST   = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_en,
  output logic       parity_odd,
  output logic [3:0] baud_sel,
  output logic [3:0] frame_len,
  output logic       stop2,
  output logic [7:0] err_cnt,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } tx_state_t;

  tx_state_t  state_r, state_nx_s;
  logic [1:0] tmo_r;
  logic [3:0] parity_r, baud_r, flen_r, stopb_r;
  logic [7:0] slot_data_r, tx_data_r, data_out_r, err_cnt_r;
  logic       slot_full_r, tx_start_r, data_valid_r, overrun_r;

  logic [3:0] addr_s, val_s;
  logic       acc_s, cmd_s, payload_s, legal_s, flen_ok_s;
  logic       rd_s, wr_try_s, wr_s, bad_s, push_s, slot_free_s;
  logic [7:0] push_data_s;

  function automatic logic [3:0] reg_mux(input logic [3:0] addr, input logic [3:0] p,
                                         input logic [3:0] b, input logic [3:0] f,
                                         input logic [3:0] s);
    case (addr)
      4'h9:    reg_mux = p;
      4'hA:    reg_mux = b;
      4'hC:    reg_mux = f;
      4'hD:    reg_mux = s;
      default: reg_mux = 4'h0;
    endcase
  endfunction

  // Byte classification and pending-slot push request
  always_comb begin
    addr_s    = rx_data[7:4];
    val_s     = rx_data[3:0];
    acc_s     = rx_valid & ~rx_err;
    cmd_s     = acc_s & rx_data[7];
    payload_s = acc_s & ~rx_data[7];
    case (addr_s)
      4'h9, 4'hA, 4'hC, 4'hD: legal_s = 1'b1;
      default:                legal_s = 1'b0;
    endcase
    flen_ok_s = (val_s >= 4'd5) && (val_s <= 4'd9);
    rd_s      = cmd_s & legal_s & (val_s == 4'hF);
    wr_try_s  = cmd_s & legal_s & (val_s != 4'hF);
    wr_s      = wr_try_s & ((addr_s != 4'hC) | flen_ok_s);
    bad_s     = (rx_valid & rx_err) | (cmd_s & ~legal_s) | (wr_try_s & ~wr_s);
`ifdef CMD_ECHO_EN
    push_s = rd_s | wr_s;
    if (rd_s) begin
      push_data_s = {addr_s, reg_mux(addr_s, parity_r, baud_r, flen_r, stopb_r)};
    end else begin
      push_data_s = rx_data;
    end
`else
    push_s      = rd_s;
    push_data_s = {addr_s, reg_mux(addr_s, parity_r, baud_r, flen_r, stopb_r)};
`endif
    // The slot drains in LOAD, so a push landing in that same cycle still fits.
    slot_free_s = ~slot_full_r | (state_r == LOAD);
  end

  // Config registers, payload path, error counter and pending slot
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_r     <= PARITY_RST;
      baud_r       <= BAUD_RST;
      flen_r       <= FLEN_RST;
      stopb_r      <= 4'h0;
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      err_cnt_r    <= 8'h00;
      slot_full_r  <= 1'b0;
      slot_data_r  <= 8'h00;
      overrun_r    <= 1'b0;
    end else begin
      if (wr_s) begin
        case (addr_s)
          4'h9:    parity_r <= val_s;
          4'hA:    baud_r   <= val_s;
          4'hC:    flen_r   <= val_s;
          4'hD:    stopb_r  <= val_s;
          default: parity_r <= parity_r;
        endcase
      end
      data_valid_r <= payload_s;
      if (payload_s) data_out_r <= rx_data;
      if (bad_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
      if (push_s && slot_free_s) begin
        slot_full_r <= 1'b1;
        slot_data_r <= push_data_s;
      end else if (state_r == LOAD) begin
        slot_full_r <= 1'b0;
      end
      if (push_s && !slot_free_s) overrun_r <= 1'b1;
    end
  end

  // TX scheduler next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (slot_full_r && !tx_busy) state_nx_s = LOAD;
        else                         state_nx_s = IDLE;
      end
      LOAD:  state_nx_s = START;
      START: state_nx_s = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)              state_nx_s = WAIT_DONE;
        else if (tmo_r == 2'd3)   state_nx_s = IDLE;
        else                      state_nx_s = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx_s = IDLE;
        else          state_nx_s = WAIT_DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // TX scheduler state, busy-wait timeout and registered TX outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      tmo_r      <= 2'd0;
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      tmo_r      <= (state_r == WAIT_BUSY) ? tmo_r + 2'd1 : 2'd0;
      tx_start_r <= (state_r == LOAD);
      if (state_r == LOAD) tx_data_r <= slot_data_r;
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign parity_en  = parity_r[0];
  assign parity_odd = parity_r[1];
  assign baud_sel   = baud_r;
  assign frame_len  = flen_r;
  assign stop2      = stopb_r[0];
  assign err_cnt    = err_cnt_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_cfg_cmd_ctrl.sv
// Directed self-checking bench for uart_cfg_cmd_ctrl (default build and CMD_ECHO_EN build).
module tb_uart_cfg_cmd_ctrl;

  logic       clk, rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, tx_busy;
  logic [7:0] tx_data, data_out, err_cnt;
  logic       tx_start, data_valid, parity_en, parity_odd, stop2, overrun;
  logic [3:0] baud_sel, frame_len;

  int total_cnt = 0;
  int pass_cnt  = 0;

  uart_cfg_cmd_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .data_out(data_out),
    .data_valid(data_valid), .parity_en(parity_en), .parity_odd(parity_odd),
    .baud_sel(baud_sel), .frame_len(frame_len), .stop2(stop2), .err_cnt(err_cnt),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tx_start must never coincide with tx_busy
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      total_cnt++;
      if (tx_busy !== 1'b0) $display("FAIL start_while_busy: tx_busy=%b required 0", tx_busy);
      else pass_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; rx_err = e;
    @(posedge clk); #1;
    rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  task automatic wait_tx(input int budget, output bit found, output int lat,
                         output logic [7:0] data, output bit pulse_ok);
    found = 1'b0; lat = 0; data = 8'h00; pulse_ok = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        found = 1'b1; lat = i; data = tx_data;
        break;
      end
    end
    if (found) begin
      @(negedge clk);
      pulse_ok = (tx_start === 1'b0);
    end
  endtask

  // A write; in the echo build its acknowledgement is drained so later latencies start from idle.
  task automatic do_write(input logic [7:0] b);
    bit f, p; int l; logic [7:0] d;
    send_byte(b, 1'b0);
`ifdef CMD_ECHO_EN
    wait_tx(20, f, l, d, p);
    repeat (6) @(negedge clk);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (parity_en !== 1'b1)   $display("FAIL rst_parity_en: got %b want 1", parity_en);   else pass_cnt++;
    total_cnt++; if (parity_odd !== 1'b0)  $display("FAIL rst_parity_odd: got %b want 0", parity_odd); else pass_cnt++;
    total_cnt++; if (frame_len !== 4'h8)   $display("FAIL rst_frame_len: got %h want 8", frame_len);   else pass_cnt++;
    total_cnt++; if (baud_sel !== 4'h0)    $display("FAIL rst_baud_sel: got %h want 0", baud_sel);     else pass_cnt++;
    total_cnt++; if (stop2 !== 1'b0)       $display("FAIL rst_stop2: got %b want 0", stop2);           else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b0)    $display("FAIL rst_tx_start: got %b want 0", tx_start);     else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'h00)    $display("FAIL rst_err_cnt: got %h want 00", err_cnt);      else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0)     $display("FAIL rst_overrun: got %b want 0", overrun);       else pass_cnt++;
    total_cnt++; if ({tx_data, data_out, data_valid} !== 17'h0)
      $display("FAIL rst_data: tx_data=%h data_out=%h data_valid=%b want all 0", tx_data, data_out, data_valid);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_write_read;
    bit f, p; int l; logic [7:0] d;
    do_write(8'h90);
    total_cnt++; if (parity_en !== 1'b0) $display("FAIL wr9_parity_en: got %b want 0", parity_en); else pass_cnt++;
    send_byte(8'h9F, 1'b0);
    wait_tx(20, f, l, d, p);
    total_cnt++; if (!f)        $display("FAIL rd9_found: got no tx_start want pulse"); else pass_cnt++;
    total_cnt++; if (d !== 8'h90) $display("FAIL rd9_tx_data: got %h want 90", d);     else pass_cnt++;
    total_cnt++; if (l != 3)    $display("FAIL rd9_latency: got %0d want 3", l);       else pass_cnt++;
    total_cnt++; if (!p)        $display("FAIL rd9_pulse_width: got >1 cycle want 1"); else pass_cnt++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_payload;
    bit f, p; int l; logic [7:0] d;
    send_byte(8'h75, 1'b0);
    total_cnt++; if (data_out !== 8'h75)  $display("FAIL pay_data_out: got %h want 75", data_out);   else pass_cnt++;
    total_cnt++; if (data_valid !== 1'b1) $display("FAIL pay_valid: got %b want 1", data_valid);    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (data_valid !== 1'b0) $display("FAIL pay_valid_drop: got %b want 0", data_valid); else pass_cnt++;
    total_cnt++; if ({parity_en, frame_len, baud_sel} !== 9'h080)
      $display("FAIL pay_cfg: got pen=%b flen=%h baud=%h want 0/8/0", parity_en, frame_len, baud_sel);
    else pass_cnt++;
    wait_tx(8, f, l, d, p);
    total_cnt++; if (f) $display("FAIL pay_no_tx: got tx_start want none"); else pass_cnt++;
  endtask

  task automatic test_frame_len;
    bit f, p; int l; logic [7:0] d;
    send_byte(8'hC4, 1'b0);
    total_cnt++; if (frame_len !== 4'h8) $display("FAIL flen4_keep: got %h want 8", frame_len); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1)   $display("FAIL flen4_err: got %0d want 1", err_cnt);   else pass_cnt++;
    send_byte(8'hCA, 1'b0);
    total_cnt++; if ({frame_len, err_cnt} !== {4'h8, 8'd2})
      $display("FAIL flen10_reject: got flen=%h err=%0d want 8/2", frame_len, err_cnt);
    else pass_cnt++;
    do_write(8'hC9);
    total_cnt++; if (frame_len !== 4'h9) $display("FAIL flen9_accept: got %h want 9", frame_len); else pass_cnt++;
    do_write(8'hC6);
    total_cnt++; if (frame_len !== 4'h6) $display("FAIL flen6_accept: got %h want 6", frame_len); else pass_cnt++;
    send_byte(8'hCF, 1'b0);
    wait_tx(20, f, l, d, p);
    total_cnt++; if (!f || d !== 8'hC6) $display("FAIL rdC_tx_data: found=%b got %h want C6", f, d); else pass_cnt++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_illegal_addr;
    bit f, p; int l; logic [7:0] d;
    send_byte(8'h8F, 1'b0);
    send_byte(8'hB3, 1'b0);
    send_byte(8'hEF, 1'b0);
    total_cnt++; if (err_cnt !== 8'd5) $display("FAIL illegal_err: got %0d want 5", err_cnt); else pass_cnt++;
    wait_tx(10, f, l, d, p);
    total_cnt++; if (f) $display("FAIL illegal_no_tx: got tx_start data %h want none", d); else pass_cnt++;
  endtask

  task automatic test_stop_bits;
    bit f, p; int l; logic [7:0] d;
    do_write(8'hD1);
    total_cnt++; if (stop2 !== 1'b1) $display("FAIL stop2_set: got %b want 1", stop2); else pass_cnt++;
    send_byte(8'hDF, 1'b0);
    wait_tx(20, f, l, d, p);
    total_cnt++; if (!f || d !== 8'hD1) $display("FAIL rdD_tx_data: found=%b got %h want D1", f, d); else pass_cnt++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_overrun;
    bit f, p; int l; logic [7:0] d;
    do_write(8'h91);
    send_byte(8'h9F, 1'b0);
    wait_tx(20, f, l, d, p);
    total_cnt++; if (!f || d !== 8'h91) $display("FAIL ovr_first: found=%b got %h want 91", f, d); else pass_cnt++;
    tx_busy = 1'b1;
    send_byte(8'hAF, 1'b0);
    send_byte(8'hA7, 1'b0);
    send_byte(8'hCF, 1'b0);
    total_cnt++; if (overrun !== 1'b1)  $display("FAIL ovr_flag: got %b want 1", overrun);   else pass_cnt++;
    total_cnt++; if (baud_sel !== 4'h7) $display("FAIL ovr_baud: got %h want 7", baud_sel); else pass_cnt++;
    wait_tx(12, f, l, d, p);
    total_cnt++; if (f) $display("FAIL ovr_hold_busy: got tx_start want none"); else pass_cnt++;
    tx_busy = 1'b0;
    wait_tx(20, f, l, d, p);
    total_cnt++; if (!f || d !== 8'hA0) $display("FAIL ovr_snapshot: found=%b got %h want A0", f, d); else pass_cnt++;
    wait_tx(12, f, l, d, p);
    total_cnt++; if (f) $display("FAIL ovr_dropped: got tx_start data %h want none", d); else pass_cnt++;
  endtask

  task automatic test_rx_err;
    do_write(8'h92);
    send_byte(8'h91, 1'b1);
    total_cnt++; if ({parity_en, parity_odd} !== 2'b01)
      $display("FAIL rxerr_parity: got en=%b odd=%b want 0/1", parity_en, parity_odd);
    else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd6) $display("FAIL rxerr_cnt: got %0d want 6", err_cnt); else pass_cnt++;
    send_byte(8'h33, 1'b1);
    total_cnt++; if (data_valid !== 1'b0) $display("FAIL rxerr_payload: got valid %b want 0", data_valid); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd7) $display("FAIL rxerr_cnt2: got %0d want 7", err_cnt); else pass_cnt++;
  endtask

  task automatic test_err_saturate;
    for (int i = 0; i < 248; i++) send_byte(8'h00, 1'b1);
    total_cnt++; if (err_cnt !== 8'hFF) $display("FAIL sat_reach: got %h want FF", err_cnt); else pass_cnt++;
    for (int i = 0; i < 3; i++) send_byte(8'hC4, 1'b0);
    total_cnt++; if (err_cnt !== 8'hFF) $display("FAIL sat_hold: got %h want FF", err_cnt); else pass_cnt++;
  endtask

  task automatic test_echo;
    bit f, p; int l; logic [7:0] d;
    send_byte(8'hA3, 1'b0);
    total_cnt++; if (baud_sel !== 4'h3) $display("FAIL echo_baud: got %h want 3", baud_sel); else pass_cnt++;
    wait_tx(20, f, l, d, p);
`ifdef CMD_ECHO_EN
    total_cnt++; if (!f || d !== 8'hA3) $display("FAIL echo_tx: found=%b got %h want A3", f, d); else pass_cnt++;
`else
    total_cnt++; if (f) $display("FAIL silent_write: got tx_start data %h want none", d); else pass_cnt++;
`endif
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    bit f, p; int l; logic [7:0] d;
    tx_busy = 1'b1;
    send_byte(8'hAF, 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; tx_busy = 1'b0;
    wait_tx(15, f, l, d, p);
    total_cnt++; if (f) $display("FAIL midrst_no_tx: got tx_start data %h want none", d); else pass_cnt++;
    total_cnt++; if ({baud_sel, err_cnt, overrun, parity_en} !== {4'h0, 8'h00, 1'b0, 1'b1})
      $display("FAIL midrst_state: baud=%h err=%h ovr=%b pen=%b want 0/00/0/1", baud_sel, err_cnt, overrun, parity_en);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; tx_busy = 1'b0;
    test_reset();
    test_write_read();
    test_payload();
    test_frame_len();
    test_illegal_addr();
    test_stop_bits();
    test_overrun();
    test_rx_err();
    test_err_saturate();
    test_echo();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
